adc_sample_ctrl: RTL

Sequencing and averaging controller for the on-chip modular ADC. It starts and stops the ADC sequencer in continuous mode through the sequencer CSR port. It consumes the ADC response stream and boxcar-averages 2^AVG_LOG2 samples per channel. It keeps the latest average for each channel for readback by the flight-control logic, and sits between the `adc` Qsys system and the board register file.

---
 rtl/adc_sample_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl: starts and stops the modular ADC sequencer in continuous
// mode through its CSR port, boxcar-averages the response stream per
// channel and keeps the latest average of each channel for readback.
module adc_sample_ctrl #(
  parameter int NUM_CH   = 9,
  parameter int AVG_LOG2 = 3
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  output logic        busy,
  output logic        seq_csr_address,
  output logic        seq_csr_read,
  output logic        seq_csr_write,
  output logic [31:0] seq_csr_writedata,
  input  logic [31:0] seq_csr_readdata,
  input  logic        rsp_valid,
  input  logic [4:0]  rsp_channel,
  input  logic [11:0] rsp_data,
  input  logic [4:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic        rd_fresh,
  input  logic        rd_ack,
  output logic        upd_pulse,
  output logic [4:0]  upd_ch,
  output logic [15:0] drop_cnt
);

  // Accumulator holds up to 2^AVG_LOG2 full-scale samples without overflow.
  localparam int ACC_W = 12 + AVG_LOG2;
  // Sample counter needs at least one bit even when every sample is a result.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [5:0] NUM_CH_EXT = 6'(NUM_CH);

  // Sequencer command words: bit0 = run, bits[3:1] = mode (000 = continuous).
  localparam logic [31:0] CMD_RUN  = 32'h0000_0001;
  localparam logic [31:0] CMD_STOP = 32'h0000_0000;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] RUN      = 3'd2;
  localparam logic [2:0] STOP     = 3'd3;
  localparam logic [2:0] POLL_RD  = 3'd4;
  localparam logic [2:0] POLL_CHK = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        csr_read_q, csr_read_d;
  logic        csr_write_q, csr_write_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic        start_clr;

  logic        upd_pulse_q;
  logic [4:0]  upd_ch_q;
  logic [15:0] drop_cnt_q;
  logic [11:0] rd_data_q;
  logic        rd_fresh_q;

  logic [NUM_CH-1:0] done_vec;
  logic [11:0]       res_pad [32];
  logic [31:0]       fresh_pad;
  logic              in_range;

  // Only the run bit of the sequencer status is of interest.
  logic [30:0] unused_readdata;
  assign unused_readdata = seq_csr_readdata[31:1];

  assign in_range = ({1'b0, rsp_channel} < NUM_CH_EXT);

  // Next-state and CSR command decode; CSR strobes are registered outputs.
  always_comb begin
    state_d     = state_q;
    csr_read_d  = 1'b0;
    csr_write_d = 1'b0;
    csr_wdata_d = 32'h0;
    start_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = START;
          start_clr = 1'b1;
        end
      end
      START: begin
        csr_write_d = 1'b1;
        csr_wdata_d = CMD_RUN;
        state_d     = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = STOP;
        end
      end
      STOP: begin
        csr_write_d = 1'b1;
        csr_wdata_d = CMD_STOP;
        state_d     = POLL_RD;
      end
      POLL_RD: begin
        csr_read_d = 1'b1;
        state_d    = POLL_CHK;
      end
      POLL_CHK: begin
        // The read strobe is on the bus during the first POLL_CHK cycle;
        // readdata is valid the cycle after, so wait until the strobe drops.
        if (!csr_read_q) begin
          state_d = seq_csr_readdata[0] ? POLL_RD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered CSR command outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      csr_read_q  <= 1'b0;
      csr_write_q <= 1'b0;
      csr_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      csr_read_q  <= csr_read_d;
      csr_write_q <= csr_write_d;
      csr_wdata_q <= csr_wdata_d;
    end
  end

  // Per-channel accumulator, sample count, result and fresh flag.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ACC_W-1:0] acc_q;
      logic [CNT_W-1:0] cnt_q;
      logic [11:0]      res_q;
      logic             fresh_q;
      logic             hit;
      logic             full;
      logic             ack_hit;
      logic [ACC_W-1:0] sum;

      assign hit     = rsp_valid && (rsp_channel == 5'(gi));
      assign full    = (cnt_q == CNT_MAX);
      assign ack_hit = rd_ack && (rd_ch == 5'(gi));
      assign sum     = acc_q + ACC_W'(rsp_data);

      assign done_vec[gi]  = hit && full;
      assign res_pad[gi]   = res_q;
      assign fresh_pad[gi] = fresh_q;

      // Accumulate; a completing sample publishes the average and restarts
      // the group, a sequencer start discards any partial group.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          acc_q   <= '0;
          cnt_q   <= '0;
          res_q   <= '0;
          fresh_q <= 1'b0;
        end else begin
          if (hit && full) begin
            res_q <= sum[AVG_LOG2 +: 12];
            acc_q <= '0;
            cnt_q <= '0;
          end else if (start_clr) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else if (hit) begin
            acc_q <= sum;
            cnt_q <= cnt_q + 1'b1;
          end
          // A new result beats an acknowledge landing in the same cycle.
          if (hit && full) begin
            fresh_q <= 1'b1;
          end else if (ack_hit) begin
            fresh_q <= 1'b0;
          end
        end
      end
    end

    // Unused channel slots read back as zero result, not fresh.
    for (gi = 0; gi < 32; gi++) begin : g_pad
      if (gi >= NUM_CH) begin : g_zero
        assign res_pad[gi]   = 12'd0;
        assign fresh_pad[gi] = 1'b0;
      end
    end
  endgenerate

  // Update strobe, drop counter and registered readback port.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      upd_pulse_q <= 1'b0;
      upd_ch_q    <= 5'd0;
      drop_cnt_q  <= 16'd0;
      rd_data_q   <= 12'd0;
      rd_fresh_q  <= 1'b0;
    end else begin
      upd_pulse_q <= |done_vec;
      if (|done_vec) begin
        upd_ch_q <= rsp_channel;
      end
      if (rsp_valid && !in_range && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      rd_data_q  <= res_pad[rd_ch];
      rd_fresh_q <= fresh_pad[rd_ch];
    end
  end

  assign busy              = (state_q != IDLE);
  assign seq_csr_address   = 1'b0;
  assign seq_csr_read      = csr_read_q;
  assign seq_csr_write     = csr_write_q;
  assign seq_csr_writedata = csr_wdata_q;
  assign upd_pulse         = upd_pulse_q;
  assign upd_ch            = upd_ch_q;
  assign drop_cnt          = drop_cnt_q;
  assign rd_data           = rd_data_q;
  assign rd_fresh          = rd_fresh_q;

endmodule
